// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO family.
// Holds read-mode selectors, default widths and the occupancy-width function.
// No logic; imported by synchronous_fifo and fifo_storage_ram.
package fifo_pkg;

  // Read-mode selectors for the fwft_mode parameter.
  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Default geometry: 16 words of 8 bits.
  localparam int FIFO_DEF_ADDR_W = 4;
  localparam int FIFO_DEF_DATA_W = 8;

  // Bits needed to hold the values 0..depth inclusive.
  function automatic int fifo_count_width(input int depth);
    int w;
    w = 1;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) <= depth) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fifo_storage_ram.sv
// Purpose: 1-write/1-read register array backing the FIFO.
// Latency: write lands on the rising edge; read port is combinational from the array.
// Backpressure: none here; the caller decides when a write is legal.
// Ports: clk, we/wr_addr/wr_data (synchronous write), rd_addr/rd_data (asynchronous read).
module fifo_storage_ram
  import fifo_pkg::*;
#(
  parameter int address_bus_length = FIFO_DEF_ADDR_W,
  parameter int data_bus_length    = FIFO_DEF_DATA_W
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [address_bus_length-1:0] wr_addr,
  input  logic [data_bus_length-1:0]    wr_data,
  input  logic [address_bus_length-1:0] rd_addr,
  output logic [data_bus_length-1:0]    rd_data
);

  localparam int depth = 2 ** address_bus_length;

  // Storage is not reset: pointers and count define what is valid.
  logic [data_bus_length-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/synchronous_fifo.sv
// Purpose: single-clock FIFO with count, threshold flags, sticky error flags, flush and FWFT option.
// Latency: standard mode data one edge after the accepting read; FWFT head visible the cycle after the write.
// Backpressure: writes refused while full (overflow sticky), reads refused while empty (underflow sticky).
// Ports: sys_clk/sys_rst (async active-low), flush, write_enable/trans_data, read_enable/recv_data,
//        fifo_full/fifo_empty/fifo_almost_full/fifo_almost_empty, fifo_count, overflow, underflow.
module synchronous_fifo
  import fifo_pkg::*;
#(
  parameter int address_bus_length = FIFO_DEF_ADDR_W,
  parameter int data_bus_length    = FIFO_DEF_DATA_W,
  parameter int almost_full_level  = 12,
  parameter int almost_empty_level = 2,
  parameter int fwft_mode          = FIFO_MODE_STD
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          flush,
  input  logic                          write_enable,
  input  logic [data_bus_length-1:0]    trans_data,
  input  logic                          read_enable,
  output logic [data_bus_length-1:0]    recv_data,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic                          fifo_almost_full,
  output logic                          fifo_almost_empty,
  output logic [address_bus_length:0]   fifo_count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int depth = 2 ** address_bus_length;
  localparam int cnt_w = fifo_count_width(depth);

  localparam logic [cnt_w-1:0] depth_c  = cnt_w'(depth);
  localparam logic [cnt_w-1:0] af_lvl   = cnt_w'(almost_full_level);
  localparam logic [cnt_w-1:0] ae_lvl   = cnt_w'(almost_empty_level);
  localparam logic [address_bus_length-1:0] ptr_one = address_bus_length'(1);

  logic [address_bus_length-1:0] wr_ptr_q, rd_ptr_q;
  logic [cnt_w-1:0]              count_q, count_nxt;
  logic                          full_q, empty_q, afull_q, aempty_q;
  logic                          ovf_q, unf_q;
  logic                          wr_acc, rd_acc;
  logic                          ram_we;
  logic [data_bus_length-1:0]    ram_rd_data;

  // Acceptance uses only the registered flags, so there is no enable-to-flag path.
  assign wr_acc = write_enable && !full_q;
  assign rd_acc = read_enable && !empty_q;

  // Gate with reset so a write request held during reset never lands in the array.
  assign ram_we = wr_acc && !flush && sys_rst;

  always_comb begin
    count_nxt = count_q;
    if (flush) begin
      count_nxt = '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count_nxt = count_q + cnt_w'(1);
        2'b01:   count_nxt = count_q - cnt_w'(1);
        default: count_nxt = count_q;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      count_q  <= count_nxt;
      full_q   <= (count_nxt == depth_c);
      empty_q  <= (count_nxt == '0);
      afull_q  <= (count_nxt >= af_lvl);
      aempty_q <= (count_nxt <= ae_lvl);
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        ovf_q    <= 1'b0;
        unf_q    <= 1'b0;
      end else begin
        if (wr_acc) wr_ptr_q <= wr_ptr_q + ptr_one;
        if (rd_acc) rd_ptr_q <= rd_ptr_q + ptr_one;
        // A write against a full FIFO drops its data, even if a read frees a slot this cycle.
        if (write_enable && full_q) ovf_q <= 1'b1;
        // A read against empty paired with a write loses nothing; the word is delivered next.
        if (read_enable && empty_q && !write_enable) unf_q <= 1'b1;
      end
    end
  end

  fifo_storage_ram #(
    .address_bus_length(address_bus_length),
    .data_bus_length   (data_bus_length)
  ) u_ram (
    .clk    (sys_clk),
    .we     (ram_we),
    .wr_addr(wr_ptr_q),
    .wr_data(trans_data),
    .rd_addr(rd_ptr_q),
    .rd_data(ram_rd_data)
  );

  generate
    if (fwft_mode == FIFO_MODE_FWFT) begin : g_fwft
      // Head word straight from the array; forced to zero while empty so it is stable.
      assign recv_data = empty_q ? '0 : ram_rd_data;
    end else begin : g_std
      logic [data_bus_length-1:0] recv_q;
      always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
          recv_q <= '0;
        end else if (!flush && rd_acc) begin
          recv_q <= ram_rd_data;
        end
      end
      assign recv_data = recv_q;
    end
  endgenerate

  assign fifo_count        = count_q;
  assign fifo_full         = full_q;
  assign fifo_empty        = empty_q;
  assign fifo_almost_full  = afull_q;
  assign fifo_almost_empty = aempty_q;
  assign overflow          = ovf_q;
  assign underflow         = unf_q;

endmodule
